// File: rtl/synch_edge_filter_if.sv
// Pin-side bundle for the multi-channel synchronizer / glitch filter / edge detector.
// master drives the raw pins and controls; slave is the filter block.
interface synch_edge_filter_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] asynch_sig_in;
    logic [1:0]        edge_sel;
    logic [NUM_CH-1:0] evt_clr;
    logic [NUM_CH-1:0] filt_lvl;
    logic [NUM_CH-1:0] edge_pulse;
    logic [NUM_CH-1:0] evt_sticky;
    logic              any_evt;

    modport master (
        output asynch_sig_in,
        output edge_sel,
        output evt_clr,
        input  filt_lvl,
        input  edge_pulse,
        input  evt_sticky,
        input  any_evt
    );

    modport slave (
        input  asynch_sig_in,
        input  edge_sel,
        input  evt_clr,
        output filt_lvl,
        output edge_pulse,
        output evt_sticky,
        output any_evt
    );
endinterface

// File: rtl/synch_edge_filter.sv
// Per-channel synchronizer chain, stability filter and selectable edge detector
// with sticky event flags; all channels independent, single clock domain.
module synch_edge_filter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    synch_edge_filter_if.slave  bus
);

    localparam int               CNT_W   = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
    logic [CNT_W-1:0]       cnt_q  [NUM_CH];
    logic [CNT_W-1:0]       cnt_d  [NUM_CH];

    logic [NUM_CH-1:0] filt_lvl_q,   filt_lvl_d;
    logic [NUM_CH-1:0] edge_pulse_q, edge_pulse_d;
    logic [NUM_CH-1:0] evt_sticky_q, evt_sticky_d;
    logic              any_evt_q,    any_evt_d;

    logic [NUM_CH-1:0] sync_out;
    logic [NUM_CH-1:0] flip;

    always_comb begin
        sync_d       = sync_q;
        cnt_d        = cnt_q;
        filt_lvl_d   = filt_lvl_q;
        edge_pulse_d = '0;
        sync_out     = '0;
        flip         = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            sync_d[c]   = {sync_q[c][SYNC_STAGES-2:0], bus.asynch_sig_in[c]};
            sync_out[c] = sync_q[c][SYNC_STAGES-1];

            // Counter only runs while the synchronized value disagrees with the level;
            // any agreement restarts the qualification window from zero.
            if (sync_out[c] != filt_lvl_q[c]) begin
                if (cnt_q[c] == CNT_MAX) begin
                    flip[c]       = 1'b1;
                    filt_lvl_d[c] = ~filt_lvl_q[c];
                    cnt_d[c]      = '0;
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_ONE;
                end
            end else begin
                cnt_d[c] = '0;
            end

            unique case (bus.edge_sel)
                2'b00:   edge_pulse_d[c] = flip[c] &  filt_lvl_d[c];
                2'b01:   edge_pulse_d[c] = flip[c] & ~filt_lvl_d[c];
                2'b10:   edge_pulse_d[c] = flip[c];
                default: edge_pulse_d[c] = 1'b0;
            endcase
        end

        // A new pulse beats a concurrent clear so no event is ever lost.
        evt_sticky_d = edge_pulse_d | (evt_sticky_q & ~bus.evt_clr);
        any_evt_d    = |evt_sticky_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            filt_lvl_q   <= '0;
            edge_pulse_q <= '0;
            evt_sticky_q <= '0;
            any_evt_q    <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                sync_q[c] <= sync_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            filt_lvl_q   <= filt_lvl_d;
            edge_pulse_q <= edge_pulse_d;
            evt_sticky_q <= evt_sticky_d;
            any_evt_q    <= any_evt_d;
        end
    end

    assign bus.filt_lvl   = filt_lvl_q;
    assign bus.edge_pulse = edge_pulse_q;
    assign bus.evt_sticky = evt_sticky_q;
    assign bus.any_evt    = any_evt_q;

endmodule

// File: tb/tb_synch_edge_filter.sv
// Bench for synch_edge_filter: directed scenarios with literal expectations, then
// random pin activity compared every cycle against a history-based reference model.
module tb_synch_edge_filter;

    localparam int NUM_CH = 4;
    localparam int SS     = 2;
    localparam int FC     = 3;
    localparam int HMAX   = 8192;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] a_in = '1;
    logic [1:0]        sel = 2'b00;
    logic [NUM_CH-1:0] clr = '0;

    synch_edge_filter_if #(.NUM_CH(NUM_CH)) sef_if ();

    assign sef_if.asynch_sig_in = a_in;
    assign sef_if.edge_sel      = sel;
    assign sef_if.evt_clr       = clr;

    synch_edge_filter #(
        .NUM_CH     (NUM_CH),
        .SYNC_STAGES(SS),
        .FILT_CYCLES(FC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sef_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the level flips at edge j when the synchronized samples seen
    // at the last FC edges all disagree with it and none of those edges precede the
    // most recent flip or reset. The synchronized sample at edge j is the pin value
    // captured SS edges earlier, or 0 if that capture was at/before a reset.
    logic [NUM_CH-1:0] in_hist [HMAX];
    int                cyc = 0;
    int                last_rst = -1;
    int                last_flip [NUM_CH];
    bit                model_valid = 1'b0;
    logic [NUM_CH-1:0] m_lvl = '0, m_pulse = '0, m_sticky = '0;
    logic              m_any = 1'b0;

    int pcnt [NUM_CH];
    int pfirst [NUM_CH];
    int plast [NUM_CH];

    function automatic logic [NUM_CH-1:0] sync_at(input int e);
        if (e - SS < 0 || e - SS <= last_rst) return '0;
        return in_hist[e - SS];
    endfunction

    task automatic model_step();
        logic [NUM_CH-1:0] s;
        logic [NUM_CH-1:0] nl;
        logic [NUM_CH-1:0] np;
        bit                ok;
        int                e;
        in_hist[cyc] = a_in;
        if (rst) begin
            m_lvl       = '0;
            m_pulse     = '0;
            m_sticky    = '0;
            m_any       = 1'b0;
            last_rst    = cyc;
            model_valid = 1'b1;
        end else begin
            nl = m_lvl;
            np = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ok = 1'b1;
                for (int i = 0; i < FC; i++) begin
                    e = cyc - i;
                    if (e <= last_rst || e <= last_flip[c]) begin
                        ok = 1'b0;
                    end else begin
                        s = sync_at(e);
                        if (s[c] == m_lvl[c]) ok = 1'b0;
                    end
                end
                if (ok) begin
                    nl[c]        = ~m_lvl[c];
                    last_flip[c] = cyc;
                    case (sel)
                        2'b00:   np[c] = nl[c];
                        2'b01:   np[c] = ~nl[c];
                        2'b10:   np[c] = 1'b1;
                        default: np[c] = 1'b0;
                    endcase
                end
            end
            m_lvl    = nl;
            m_pulse  = np;
            m_sticky = np | (m_sticky & ~clr);
            m_any    = |m_sticky;
        end
        cyc++;
    endtask

    task automatic cmp(input string nm, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic zero_counts();
        for (int c = 0; c < NUM_CH; c++) begin
            pcnt[c]   = 0;
            pfirst[c] = -1;
            plast[c]  = -1;
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (model_valid) begin
                cmp("filt_lvl",   sef_if.filt_lvl,   m_lvl);
                cmp("edge_pulse", sef_if.edge_pulse, m_pulse);
                cmp("evt_sticky", sef_if.evt_sticky, m_sticky);
                cmp("any_evt",    {{(NUM_CH-1){1'b0}}, sef_if.any_evt}, {{(NUM_CH-1){1'b0}}, m_any});
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (sef_if.edge_pulse[c] === 1'b1) begin
                    pcnt[c]++;
                    if (pfirst[c] < 0) pfirst[c] = cyc;
                    plast[c] = cyc;
                end
            end
        end
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) last_flip[c] = -1;
        zero_counts();

        // Reset with all pins already high, then start-up rise after 5 edges.
        tick(1);
        chk("rst_filt", 32'(sef_if.filt_lvl), 0);
        chk("rst_any", 32'(sef_if.any_evt), 0);
        tick(1);
        chk("rst_sticky", 32'(sef_if.evt_sticky), 0);
        rst = 1'b0;
        tick(4);
        chk("startup_filt_e4", 32'(sef_if.filt_lvl), 0);
        tick(1);
        chk("startup_filt", 32'(sef_if.filt_lvl), 15);
        chk("startup_pulse", 32'(sef_if.edge_pulse), 15);
        chk("startup_sticky", 32'(sef_if.evt_sticky), 15);
        chk("startup_any", 32'(sef_if.any_evt), 1);
        chk("model_startup_pulse", 32'(m_pulse), 15);
        tick(1);
        chk("startup_pulse_once", 32'(sef_if.edge_pulse), 0);
        chk("startup_sticky_hold", 32'(sef_if.evt_sticky), 15);

        // Drop everything (rise mode, no pulses), then clear flags.
        a_in = '0;
        tick(8);
        clr = '1;
        tick(1);
        clr = '0;
        chk("clear_all_sticky", 32'(sef_if.evt_sticky), 0);
        chk("clear_all_any", 32'(sef_if.any_evt), 0);

        // Glitch rejection: 2-cycle excursion ignored, 3-cycle excursion accepted.
        zero_counts();
        a_in[0] = 1'b1;
        tick(2);
        a_in[0] = 1'b0;
        tick(8);
        chk("glitch_pulses", pcnt[0], 0);
        chk("glitch_filt", 32'(sef_if.filt_lvl[0]), 0);
        a_in[0] = 1'b1;
        tick(3);
        a_in[0] = 1'b0;
        tick(1);
        chk("accept_filt_e4", 32'(sef_if.filt_lvl[0]), 0);
        tick(1);
        chk("accept_filt", 32'(sef_if.filt_lvl[0]), 1);
        chk("accept_pulse", 32'(sef_if.edge_pulse[0]), 1);
        chk("model_accept_lvl", 32'(m_lvl[0]), 1);
        tick(8);
        chk("accept_pulse_count", pcnt[0], 1);
        chk("accept_fell_back", 32'(sef_if.filt_lvl[0]), 0);

        // Both-edges mode on ch1.
        sel = 2'b10;
        zero_counts();
        a_in[1] = 1'b1;
        tick(10);
        a_in[1] = 1'b0;
        tick(10);
        chk("both_pulse_count", pcnt[1], 2);
        chk("both_pulse_gap", plast[1] - pfirst[1], 10);

        // Fall-only mode on ch3.
        sel = 2'b01;
        zero_counts();
        a_in[3] = 1'b1;
        tick(8);
        a_in[3] = 1'b0;
        tick(8);
        chk("fall_pulse_count", pcnt[3], 1);
        chk("fall_level_low", 32'(sef_if.filt_lvl[3]), 0);

        // None mode: level tracks, no pulses or flags.
        sel = 2'b11;
        clr = '1;
        tick(1);
        clr = '0;
        zero_counts();
        a_in = 4'b0101;
        tick(8);
        chk("none_filt_hi", 32'(sef_if.filt_lvl), 5);
        a_in = '0;
        tick(8);
        chk("none_filt_lo", 32'(sef_if.filt_lvl), 0);
        chk("none_pulses", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
        chk("none_sticky", 32'(sef_if.evt_sticky), 0);

        // Clear collides with the pulse on ch2: set wins, next clear drops it.
        sel = 2'b00;
        a_in[2] = 1'b1;
        tick(4);
        clr[2] = 1'b1;
        tick(1);
        chk("collide_pulse", 32'(sef_if.edge_pulse[2]), 1);
        chk("collide_sticky", 32'(sef_if.evt_sticky[2]), 1);
        chk("collide_any", 32'(sef_if.any_evt), 1);
        tick(1);
        chk("cleared_sticky", 32'(sef_if.evt_sticky[2]), 0);
        chk("cleared_any", 32'(sef_if.any_evt), 0);
        clr = '0;

        // Reset mid-filter on ch0; full latency restarts from release.
        a_in[0] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("midrst_filt", 32'(sef_if.filt_lvl), 0);
        chk("midrst_pulse", 32'(sef_if.edge_pulse), 0);
        chk("midrst_sticky", 32'(sef_if.evt_sticky), 0);
        rst = 1'b0;
        tick(4);
        chk("midrst_filt_e4", 32'(sef_if.filt_lvl[0]), 0);
        tick(1);
        chk("midrst_filt_e5", 32'(sef_if.filt_lvl), 5);
        chk("midrst_pulse_e5", 32'(sef_if.edge_pulse), 5);
        chk("model_midrst_lvl", 32'(m_lvl), 5);

        // Random pin activity, mode changes, clears and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 5) == 0) a_in[c] = ~a_in[c];
            if ($urandom_range(0, 39) == 0) sel = 2'($urandom_range(0, 3));
            clr = '0;
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 9) == 0) clr[c] = 1'b1;
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        clr = '0;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/synch_edge_filter.md
Name: synch_edge_filter

Overview:
- Multi-channel successor to the single-bit synchronizer/rising-edge detector.
- Each channel carries an asynchronous input through a parametrised synchronizer chain and a stability (glitch) filter, then a runtime-selectable edge detector.
- Each channel provides a filtered level, a one-cycle edge pulse and a sticky event flag with a clear handshake.
- Sits between external pins (buttons, sensor strobes) and control FSMs.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchronizer flops per channel (>=2)
FILT_CYCLES, 3, consecutive cycles the synchronized value must differ from the filtered level before the level flips (>=1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
asynch_sig_in  input  NUM_CH  asynchronous raw inputs, one bit per channel
edge_sel  input  2  detect mode, global: 00 rise, 01 fall, 10 both, 11 none
evt_clr  input  NUM_CH  per-channel sticky-flag clear, sampled each cycle
filt_lvl  output  NUM_CH  debounced, synchronized level
edge_pulse  output  NUM_CH  one-cycle pulse on a qualifying filtered transition
evt_sticky  output  NUM_CH  latched event flags
any_evt  output  1  OR-reduction of evt_sticky

Behaviour:
- Reset: on a clock edge with rst=1, these all go to 0: every synchronizer flop, filter counter, filt_lvl, edge_pulse, evt_sticky and any_evt. Reset overrides all other inputs, including reset asserted mid-filter or mid-pulse; no pulse or flag survives it.
- Synchronizer: per channel, a plain shift chain of SYNC_STAGES flops. sync_out is the last stage. No logic between stages.
- Filter counter, per channel:
  - Width is clog2(FILT_CYCLES+1).
  - sync_out == filt_lvl: counter is set to 0.
  - sync_out != filt_lvl and counter == FILT_CYCLES-1: filt_lvl inverts and counter is set to 0.
  - Otherwise the counter increments.
  - The counter never exceeds FILT_CYCLES-1 and never wraps.
- Glitch rejection: a synchronized excursion shorter than FILT_CYCLES cycles returns the counter to 0 and leaves filt_lvl unchanged.
- Latency: the input goes high before rising edge 0 and stays stable. filt_lvl flips on edge SYNC_STAGES+FILT_CYCLES-1, i.e. visible after SYNC_STAGES+FILT_CYCLES edges.
- edge_pulse:
  - Registered on the same edge as the filt_lvl flip. High for exactly one cycle.
  - Qualifying flips per edge_sel: 00 = 0->1 only; 01 = 1->0 only; 10 = either; 11 = none.
  - edge_sel is sampled on the flip edge. Changing edge_sel never by itself generates a pulse.
  - A pulse is never repeated while the level is held.
- evt_sticky, per channel:
  - Set on any cycle whose registered edge_pulse is being set.
  - Cleared when evt_clr=1 and no new pulse is being set that cycle.
  - Simultaneous set and clear: set wins, flag stays 1.
  - Holding evt_clr high continuously clears every subsequent event one cycle after it.
- any_evt: registered OR of next-state evt_sticky, so it tracks evt_sticky with zero relative skew.
- Channels: fully independent. Simultaneous events on several channels produce simultaneous pulses.
- Start-up: an input already high at reset release appears as a 0->1 transition. It yields a rise pulse after SYNC_STAGES+FILT_CYCLES edges.
- Metastability: handled only by the chain. No other reset or CDC assumptions.

Test Plan:
All tests use NUM_CH=4, SYNC_STAGES=2, FILT_CYCLES=3.
1. Reset with start-up input: rst=1 for 2 cycles with asynch_sig_in=4'hF, edge_sel=00 -> all outputs 0 during reset. After release: filt_lvl=4'hF and edge_pulse=4'hF for exactly 1 cycle after the 5th edge; evt_sticky=4'hF, any_evt=1.
2. Glitch rejection: ch0 pulse of 2 cycles -> filt_lvl[0]=0, no edge_pulse[0]. Then ch0 high for 3 cycles -> filt_lvl[0]=1 after 5 edges and one edge_pulse[0].
3. Both-edges mode: edge_sel=10, ch1 high for 10 cycles then low -> two edge_pulse[1] pulses, 10 cycles apart, each 1 cycle wide.
4. Fall and none modes:
   - edge_sel=01, ch3 rises then falls -> only the fall pulses.
   - edge_sel=11 -> filt_lvl still tracks the input, with no pulses and no sticky flags.
5. Clear collision: evt_clr[2]=1 on the same cycle edge_pulse[2] is set -> evt_sticky[2]=1. evt_clr[2]=1 on the next cycle -> 0, and any_evt drops when all flags are 0.
6. Reset mid-filter: ch0 differs for 2 filtered cycles, then rst=1 for 1 cycle -> counter, filt_lvl, pulses and flags are all 0. The filter restarts a full 5-edge latency from release.
